mqfu_axil_sequencer: RTL and testbench
======================================

# mqfu_axil_sequencer

AXI4-Lite–controlled sequencer for the Madgwick Quaternion Filter Unit (MQFU) core. Software writes one IMU sample, triggers an update (or enables auto-trigger), and reads back the quaternion. The block holds the register file, snapshots the sample into the core, pulses the core start, bounds the wait with a timeout, latches the result and raises an interrupt. It sits between the AXI4-Lite interconnect and the MQFU datapath, inside the MQFU AXI4-Lite IP.

## Interface
- C_S_AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6: byte address width, giving 16 word slots.
- TIMEOUT_CYCLES, 4096: maximum cycles to wait for core_done; must be ≥ 2.
- ACLK in 1: single clock.
- ARESETN in 1: asynchronous, active-low reset.
- S_AXI_AW{ADDR,PROT,VALID,READY}, S_AXI_W{DATA,STRB,VALID,READY}, S_AXI_B{RESP,VALID,READY}, S_AXI_AR{ADDR,PROT,VALID,READY}, S_AXI_R{DATA,RESP,VALID,READY}: standard AXI4-Lite slave ports; PROT is ignored; RESP is always OKAY (2'b00).
- core_start out 1: one-cycle pulse that launches a filter update.
- core_sample out 96: {az,ay,ax,gz,gy,gx}, each 16-bit signed; held stable from the start pulse until the next launch.
- core_done in 1: one-cycle pulse; core_q is valid in the same cycle.
- core_q in 128: {q3,q2,q1,q0}, each 32 bits.
- irq out 1: level interrupt, registered.

## Operation
- Register map (byte offsets):
  - 0x00 CTRL: RW. bit0 START (write-1, self-clearing, reads 0); bit1 IRQ_EN; bit2 AUTO.
  - 0x04 STATUS: bit0 BUSY (RO); bit1 DONE, bit2 TIMEOUT, bit3 OVERRUN (all sticky, write-1-to-clear).
  - 0x08 GXY: {gy,gx}. 0x0C GZAX: {ax,gz}. 0x10 AYZ: {az,ay}. All RW.
  - 0x14 COUNT: RO, completed updates, wraps at 2^32.
  - 0x20–0x2C Q0–Q3: RO.
  - Unmapped addresses read 0; writes to them are ignored.
- WSTRB is honoured per byte on RW registers. START and the W1C bits act only when WSTRB[0]=1.
- Trigger sources:
  - A write of START=1.
  - With AUTO=1, any write to AYZ.
- FSM states IDLE, LAUNCH, WAIT:
  - IDLE + trigger → LAUNCH.
  - LAUNCH: snapshot GXY/GZAX/AYZ into core_sample, assert core_start for one cycle, clear the timeout counter, then → WAIT.
  - WAIT + core_done → IDLE: latch Q0–Q3, set DONE, increment COUNT.
  - WAIT with counter reaching TIMEOUT_CYCLES-1 and no done → IDLE: set TIMEOUT; Q and COUNT are unchanged.
- BUSY = (state != IDLE).
- A trigger while BUSY sets OVERRUN and is otherwise dropped; it is not queued.
- core_done outside WAIT is ignored.
- Sample registers may be rewritten during WAIT; the new values take effect at the next launch only.
- Set has priority over W1C when both hit the same bit in the same cycle.
- irq is registered from IRQ_EN & (DONE | TIMEOUT | OVERRUN).

## Timing
- Reset values:
  - All registers 0.
  - All READY/VALID outputs 0; BRESP/RRESP 0; RDATA 0.
  - core_start 0, core_sample 0, irq 0, state IDLE.
- Reset asserted mid-operation returns everything to reset values immediately. An in-flight core_done is lost.
- Write channel:
  - AWREADY and WREADY are asserted together for exactly one cycle when AWVALID & WVALID & !BVALID.
  - The register update happens on that same edge.
  - BVALID rises the next cycle and is held until BREADY.
  - A lone AWVALID or lone WVALID waits for the other.
- Read channel:
  - ARREADY is asserted for one cycle when ARVALID & !RVALID.
  - RDATA/RVALID are registered the next cycle and held until RREADY.
  - Reads and writes may proceed in the same cycle.
  - A read in the same cycle as a W1C returns the pre-clear value.
- Trigger latency: trigger write accepted at edge T → LAUNCH during cycle T+1 (core_start high) → WAIT from T+2. BUSY reads 1 from T+1.
- Completion latency: core_done high in cycle D → Q, DONE, COUNT and BUSY=0 visible from D+1; irq high from D+2.
- Timeout: the TIMEOUT flag appears exactly TIMEOUT_CYCLES cycles after the first WAIT cycle.

## Structure
- Package mqfu_axil_sequencer_pkg holds:
  - register byte-offset localparams;
  - CTRL/STATUS bit-index localparams;
  - state_t enum {IDLE, LAUNCH, WAIT};
  - the sample and quaternion field widths (16, 32).
- Sub-module mqfu_seq_fsm holds the FSM, the timeout counter, core_start and the result latch.
  - Inputs: trigger, core_done, core_q.
  - Outputs: busy, done_set, timeout_set, overrun_set, core_start, q registers.
- The top level holds the AXI4-Lite handshakes, the register file and irq.

## Test plan
- Reset with ARESETN low 200 ns → every register reads 0; BVALID=RVALID=core_start=irq=0.
- Write GXY=0x0002_0001, GZAX=0x0004_0003, AYZ=0x0006_0005, then CTRL=0x3; model returns core_done after 10 cycles with q=128'h4_3_2_1 → core_sample=96'h0006_0005_0004_0003_0002_0001; one core_start pulse; Q0..Q3 read 1,2,3,4; COUNT=1; STATUS=0x2; irq=1. Write STATUS=0x2 → irq=0.
- AUTO=1, IRQ_EN=0, three writes to AYZ spaced 20 cycles apart, model done latency 5 → COUNT=3, exactly 3 core_start pulses, irq stays 0.
- START with core_done never asserted, TIMEOUT_CYCLES=16 → STATUS=0x4 exactly 16 cycles after the first WAIT cycle; Q unchanged; COUNT unchanged.
- Second START issued while BUSY → OVERRUN=1; only one core_start pulse; first update completes normally.
- Back-pressure: hold BREADY/RREADY low for 5 cycles; write to 0x3C; AW issued 3 cycles before W → BVALID/RVALID held stable, no second accept, 0x3C reads 0; ARESETN pulsed low during WAIT → all state cleared, later core_done ignored.

Source files
------------

// File: rtl/mqfu_axil_sequencer_pkg.sv
// Shared definitions for the MQFU AXI4-Lite sequencer: register map, bit
// positions, FSM state encoding and sample/quaternion field widths.
package mqfu_axil_sequencer_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int QUAT_W      = 32;
  localparam int SAMPLE_BITS = 6 * SAMPLE_W;
  localparam int QUAT_BITS   = 4 * QUAT_W;

  localparam logic [5:0] OFF_CTRL   = 6'h00;
  localparam logic [5:0] OFF_STATUS = 6'h04;
  localparam logic [5:0] OFF_GXY    = 6'h08;
  localparam logic [5:0] OFF_GZAX   = 6'h0C;
  localparam logic [5:0] OFF_AYZ    = 6'h10;
  localparam logic [5:0] OFF_COUNT  = 6'h14;
  localparam logic [5:0] OFF_Q0     = 6'h20;
  localparam logic [5:0] OFF_Q1     = 6'h24;
  localparam logic [5:0] OFF_Q2     = 6'h28;
  localparam logic [5:0] OFF_Q3     = 6'h2C;

  localparam int CTRL_START   = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_AUTO    = 2;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_OVERRUN = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  // Byte-lane merge of a write into a 32-bit register.
  function automatic logic [31:0] strb_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? wd[8*b +: 8] : cur[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mqfu_seq_fsm.sv
// Launch/wait sequencer for the MQFU core: snapshots the sample, pulses
// core_start, bounds the wait for core_done and latches the quaternion.
module mqfu_seq_fsm
  import mqfu_axil_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   trigger,
  input  logic [SAMPLE_BITS-1:0] sample_next,
  input  logic                   core_done,
  input  logic [QUAT_BITS-1:0]   core_q,
  output logic                   busy,
  output logic                   done_set,
  output logic                   timeout_set,
  output logic                   overrun_set,
  output logic                   core_start,
  output logic [SAMPLE_BITS-1:0] core_sample,
  output logic [QUAT_BITS-1:0]   q
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   core_start_r;
  logic [SAMPLE_BITS-1:0] core_sample_r;
  logic [QUAT_BITS-1:0]   q_r;

  // Status flag events are combinational so the top can set them on the same edge.
  assign busy        = (state_r != IDLE);
  assign done_set    = (state_r == WAIT) && core_done;
  assign timeout_set = (state_r == WAIT) && !core_done && (cnt_r == CNT_LAST);
  assign overrun_set = trigger && (state_r != IDLE);

  assign core_start  = core_start_r;
  assign core_sample = core_sample_r;
  assign q           = q_r;

  // Sequencer state, timeout counter, start pulse, sample snapshot and result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      core_start_r  <= 1'b0;
      core_sample_r <= {SAMPLE_BITS{1'b0}};
      q_r           <= {QUAT_BITS{1'b0}};
    end else begin
      core_start_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (trigger) begin
            state_r       <= LAUNCH;
            core_start_r  <= 1'b1;
            core_sample_r <= sample_next;
          end else begin
            state_r <= IDLE;
          end
        end
        LAUNCH: begin
          state_r <= WAIT;
          cnt_r   <= {CNT_W{1'b0}};
        end
        WAIT: begin
          if (core_done) begin
            q_r     <= core_q;
            state_r <= IDLE;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mqfu_axil_sequencer.sv
// AXI4-Lite front end for the MQFU sequencer: handshakes, register file,
// trigger generation and the level interrupt.
module mqfu_axil_sequencer
  import mqfu_axil_sequencer_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int TIMEOUT_CYCLES     = 4096
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            core_start,
  output logic [SAMPLE_BITS-1:0]          core_sample,
  input  logic                            core_done,
  input  logic [QUAT_BITS-1:0]            core_q,
  output logic                            irq
);

  logic        awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
  logic [31:0] rdata_r;
  logic        irq_en_r, auto_r, done_r, timeout_r, overrun_r, irq_r;
  logic [31:0] gxy_r, gzax_r, ayz_r, count_r;

  logic        wr_fire_s, rd_fire_s, trigger_s, ctrl_wr_s, stat_clr_s;
  logic [5:0]  wr_off_s, rd_off_s;
  logic [31:0] gxy_nx_s, gzax_nx_s, ayz_nx_s, rd_data_s;
  logic        busy_s, done_set_s, timeout_set_s, overrun_set_s;
  logic [QUAT_BITS-1:0] q_s;
  logic        unused_s;

  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_fire_s = awready_r && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_fire_s = arready_r && S_AXI_ARVALID;
  assign wr_off_s  = {S_AXI_AWADDR[5:2], 2'b00};
  assign rd_off_s  = {S_AXI_ARADDR[5:2], 2'b00};
  assign ctrl_wr_s  = wr_fire_s && (wr_off_s == OFF_CTRL) && S_AXI_WSTRB[0];
  assign stat_clr_s = wr_fire_s && (wr_off_s == OFF_STATUS) && S_AXI_WSTRB[0];

  // Next values of the sample registers; the FSM snapshots these so an
  // AUTO-triggering AYZ write launches with the freshly written data.
  always_comb begin
    gxy_nx_s  = gxy_r;
    gzax_nx_s = gzax_r;
    ayz_nx_s  = ayz_r;
    trigger_s = 1'b0;
    if (wr_fire_s) begin
      case (wr_off_s)
        OFF_GXY:  gxy_nx_s  = strb_merge(gxy_r, S_AXI_WDATA, S_AXI_WSTRB);
        OFF_GZAX: gzax_nx_s = strb_merge(gzax_r, S_AXI_WDATA, S_AXI_WSTRB);
        OFF_AYZ:  ayz_nx_s  = strb_merge(ayz_r, S_AXI_WDATA, S_AXI_WSTRB);
        default:  gxy_nx_s  = gxy_r;
      endcase
      trigger_s = (ctrl_wr_s && S_AXI_WDATA[CTRL_START]) ||
                  (auto_r && (wr_off_s == OFF_AYZ));
    end else begin
      trigger_s = 1'b0;
    end
  end

  // Read data multiplexer over the current register contents.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    case (rd_off_s)
      OFF_CTRL:   rd_data_s = {29'd0, auto_r, irq_en_r, 1'b0};
      OFF_STATUS: rd_data_s = {28'd0, overrun_r, timeout_r, done_r, busy_s};
      OFF_GXY:    rd_data_s = gxy_r;
      OFF_GZAX:   rd_data_s = gzax_r;
      OFF_AYZ:    rd_data_s = ayz_r;
      OFF_COUNT:  rd_data_s = count_r;
      OFF_Q0:     rd_data_s = q_s[31:0];
      OFF_Q1:     rd_data_s = q_s[63:32];
      OFF_Q2:     rd_data_s = q_s[95:64];
      OFF_Q3:     rd_data_s = q_s[127:96];
      default:    rd_data_s = 32'h0000_0000;
    endcase
  end

  // AXI handshakes: one-cycle ready pulses, response valids held until accepted.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'h0000_0000;
    end else begin
      awready_r <= !awready_r && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_r;
      wready_r  <= !awready_r && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_r;
      arready_r <= !arready_r && S_AXI_ARVALID && !rvalid_r;
      if (wr_fire_s) begin
        bvalid_r <= 1'b1;
      end else if (S_AXI_BREADY) begin
        bvalid_r <= 1'b0;
      end
      if (rd_fire_s) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rd_data_s;
      end else if (S_AXI_RREADY) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  // Register file, sticky status (set wins over W1C), completion count and irq.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      irq_en_r  <= 1'b0;
      auto_r    <= 1'b0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      overrun_r <= 1'b0;
      gxy_r     <= 32'h0000_0000;
      gzax_r    <= 32'h0000_0000;
      ayz_r     <= 32'h0000_0000;
      count_r   <= 32'h0000_0000;
      irq_r     <= 1'b0;
    end else begin
      gxy_r  <= gxy_nx_s;
      gzax_r <= gzax_nx_s;
      ayz_r  <= ayz_nx_s;
      if (ctrl_wr_s) begin
        irq_en_r <= S_AXI_WDATA[CTRL_IRQ_EN];
        auto_r   <= S_AXI_WDATA[CTRL_AUTO];
      end
      done_r    <= done_set_s    || (done_r    && !(stat_clr_s && S_AXI_WDATA[STAT_DONE]));
      timeout_r <= timeout_set_s || (timeout_r && !(stat_clr_s && S_AXI_WDATA[STAT_TIMEOUT]));
      overrun_r <= overrun_set_s || (overrun_r && !(stat_clr_s && S_AXI_WDATA[STAT_OVERRUN]));
      if (done_set_s) begin
        count_r <= count_r + 32'd1;
      end
      irq_r <= irq_en_r && (done_r || timeout_r || overrun_r);
    end
  end

  mqfu_seq_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fsm (
    .clk         (ACLK),
    .rst_n       (ARESETN),
    .trigger     (trigger_s),
    .sample_next ({ayz_nx_s, gzax_nx_s, gxy_nx_s}),
    .core_done   (core_done),
    .core_q      (core_q),
    .busy        (busy_s),
    .done_set    (done_set_s),
    .timeout_set (timeout_set_s),
    .overrun_set (overrun_set_s),
    .core_start  (core_start),
    .core_sample (core_sample),
    .q           (q_s)
  );

  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = wready_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RDATA   = rdata_r;
  assign S_AXI_RRESP   = 2'b00;
  assign irq           = irq_r;

endmodule

// File: tb/tb_mqfu_axil_sequencer.sv
// Directed bench for mqfu_axil_sequencer with a latency-programmable core model.
module tb_mqfu_axil_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [5:0]   awaddr = 6'h00, araddr = 6'h00;
  logic [2:0]   awprot = 3'd0, arprot = 3'd0;
  logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
  logic [31:0]  wdata = 32'h0;
  logic [3:0]   wstrb = 4'h0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic         core_start, core_done = 1'b0, irq;
  logic [95:0]  core_sample;
  logic [127:0] core_q = 128'h0;

  int checks = 0, errors = 0;
  int cyc = 0;
  int done_lat = 0, cd_cnt = 0, start_cnt = 0;
  int start_cyc = -1, done_cyc = -1, irq_cyc = -1;
  int aw_acc = 0, ar_acc = 0;
  logic irq_prev = 1'b0, irq_seen = 1'b0;
  logic [127:0] model_q = 128'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mqfu_axil_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .core_start(core_start), .core_sample(core_sample), .core_done(core_done),
    .core_q(core_q), .irq(irq)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Core model: done pulse done_lat cycles after start (never when done_lat==0).
  initial begin
    forever begin
      @(posedge clk); #1;
      core_done = 1'b0;
      if (core_start) begin
        cd_cnt = done_lat;
      end else if (cd_cnt > 0) begin
        cd_cnt--;
        if (cd_cnt == 0) begin
          core_done = 1'b1;
          core_q    = model_q;
        end
      end
    end
  end

  // Event monitor sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (core_start) begin start_cnt++; start_cyc = cyc; end
      if (core_done) done_cyc = cyc;
      if (irq && !irq_prev) irq_cyc = cyc;
      if (irq) irq_seen = 1'b1;
      irq_prev = irq;
      if (awready && awvalid && wvalid) aw_acc++;
      if (arready && arvalid) ar_acc++;
    end
  end

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(posedge clk); #1;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 20) begin @(negedge clk); n++; end
    check_val("aw_accept", awready, 1'b1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    check_val("bvalid", bvalid, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data);
    int n;
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    if (!rvalid) check_val("rvalid_timeout", rvalid, 1'b1);
    data = rdata;
    @(posedge clk); #1;
  endtask

  task automatic read_check(input string tag, input logic [5:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(addr, d);
    check_val(tag, d, exp);
  endtask

  initial begin
    logic [5:0] offs [10];
    logic ok;
    int n, rel_cyc;
    offs = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h20, 6'h24, 6'h28, 6'h2C};

    // Reset state
    #200;
    check_val("rst_bvalid", bvalid, 1'b0);
    check_val("rst_rvalid", rvalid, 1'b0);
    check_val("rst_start", core_start, 1'b0);
    check_val("rst_irq", irq, 1'b0);
    check_val("rst_sample", core_sample, 96'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 10; i++) read_check($sformatf("rst_reg_%0h", offs[i]), offs[i], 32'h0);

    // Basic update with IRQ_EN
    done_lat = 10; model_q = 128'h00000004_00000003_00000002_00000001;
    axi_write(6'h08, 32'h0002_0001, 4'hF);
    axi_write(6'h0C, 32'h0004_0003, 4'hF);
    axi_write(6'h10, 32'h0006_0005, 4'hF);
    axi_write(6'h00, 32'h0000_0003, 4'hF);
    check_val("sample_snap", core_sample, 96'h0006_0005_0004_0003_0002_0001);
    read_check("busy", 6'h04, 32'h1);
    repeat (20) @(posedge clk);
    check_val("start_pulses", start_cnt, 1);
    read_check("q0", 6'h20, 32'h1);
    read_check("q1", 6'h24, 32'h2);
    read_check("q2", 6'h28, 32'h3);
    read_check("q3", 6'h2C, 32'h4);
    read_check("count1", 6'h14, 32'h1);
    read_check("status_done", 6'h04, 32'h2);
    read_check("ctrl_rd", 6'h00, 32'h2);
    check_val("irq_set", irq, 1'b1);
    check_val("irq_latency", irq_cyc - done_cyc, 2);
    axi_write(6'h04, 32'h0000_0002, 4'hF);
    @(negedge clk);
    check_val("irq_clr", irq, 1'b0);

    // AUTO trigger, IRQ disabled
    start_cnt = 0; irq_seen = 1'b0; done_lat = 5;
    model_q = 128'h00000008_00000007_00000006_00000005;
    axi_write(6'h00, 32'h0000_0004, 4'hF);
    axi_write(6'h10, 32'h0007_0008, 4'hF);
    repeat (20) @(posedge clk);
    axi_write(6'h10, 32'h0009_000A, 4'hF);
    repeat (20) @(posedge clk);
    axi_write(6'h10, 32'h000B_000C, 4'hF);
    repeat (20) @(posedge clk);
    check_val("auto_starts", start_cnt, 3);
    check_val("auto_sample", core_sample, 96'h000B_000C_0004_0003_0002_0001);
    read_check("auto_count", 6'h14, 32'h4);
    read_check("auto_q0", 6'h20, 32'h5);
    check_val("auto_irq_quiet", irq_seen, 1'b0);
    axi_write(6'h04, 32'h0000_000F, 4'h2);
    read_check("w1c_needs_strb0", 6'h04, 32'h2);
    axi_write(6'h04, 32'h0000_0002, 4'h1);
    read_check("w1c_done", 6'h04, 32'h0);

    // Byte strobes on sample registers
    axi_write(6'h08, 32'hFFFF_FFFF, 4'h1);
    read_check("strb_gxy", 6'h08, 32'h0002_00FF);
    axi_write(6'h0C, 32'hAAAA_5555, 4'hC);
    read_check("strb_gzax", 6'h0C, 32'hAAAA_0003);

    // Timeout: core never answers
    start_cnt = 0; done_lat = 0; irq_cyc = -1;
    axi_write(6'h00, 32'h0000_0003, 4'hF);
    n = 0;
    while (irq_cyc < 0 && n < 60) begin @(posedge clk); n++; end
    check_val("to_irq_cycle", irq_cyc - start_cyc, 18);
    read_check("to_status", 6'h04, 32'h4);
    read_check("to_q0", 6'h20, 32'h5);
    read_check("to_q3", 6'h2C, 32'h8);
    read_check("to_count", 6'h14, 32'h4);
    axi_write(6'h04, 32'h0000_0004, 4'h1);
    read_check("to_clr", 6'h04, 32'h0);

    // Overrun: second START while busy
    start_cnt = 0; done_lat = 10;
    axi_write(6'h00, 32'h0000_0001, 4'hF);
    axi_write(6'h00, 32'h0000_0001, 4'hF);
    repeat (30) @(posedge clk);
    check_val("ovr_starts", start_cnt, 1);
    read_check("ovr_status", 6'h04, 32'hA);
    read_check("ovr_count", 6'h14, 32'h5);
    axi_write(6'h04, 32'h0000_000A, 4'h1);

    // Write back-pressure, AW ahead of W, unmapped address
    aw_acc = 0; ar_acc = 0; ok = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; awaddr = 6'h3C; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1'b1;
    repeat (3) begin @(negedge clk); if (awready) ok = 1'b0; end
    check_val("aw_alone_waits", ok, 1'b1);
    @(posedge clk); #1; wvalid = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    check_val("bp_bvalid", bvalid, 1'b1);
    ok = 1'b1;
    repeat (5) begin @(negedge clk); if (!bvalid || awready) ok = 1'b0; end
    check_val("bp_bhold", ok, 1'b1);
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(posedge clk); @(negedge clk);
    check_val("bp_bdrop", bvalid, 1'b0);
    check_val("bp_aw_once", aw_acc, 1);

    // Read back-pressure
    @(posedge clk); #1; rready = 1'b0; araddr = 6'h3C; arvalid = 1'b1;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    check_val("bp_rdata", {rvalid, rdata}, {1'b1, 32'h0});
    ok = 1'b1;
    repeat (5) begin @(negedge clk); if (!rvalid || arready || rdata != 32'h0) ok = 1'b0; end
    check_val("bp_rhold", ok, 1'b1);
    @(posedge clk); #1; arvalid = 1'b0; rready = 1'b1;
    @(posedge clk); @(negedge clk);
    check_val("bp_rdrop", rvalid, 1'b0);
    check_val("bp_ar_once", ar_acc, 1);

    // Reset during WAIT; the late core_done must be ignored
    done_lat = 8; model_q = 128'h1;
    axi_write(6'h00, 32'h0000_0003, 4'hF);
    @(posedge clk); #1; rst_n = 1'b0; #1;
    check_val("mid_rst_sample", core_sample, 96'h0);
    check_val("mid_rst_start", core_start, 1'b0);
    check_val("mid_rst_irq", irq, 1'b0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; rel_cyc = cyc;
    repeat (20) @(posedge clk);
    check_val("late_done_seen", done_cyc > rel_cyc, 1'b1);
    read_check("mrst_count", 6'h14, 32'h0);
    read_check("mrst_status", 6'h04, 32'h0);
    read_check("mrst_q0", 6'h20, 32'h0);
    read_check("mrst_gxy", 6'h08, 32'h0);
    read_check("mrst_ctrl", 6'h00, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
